// File: rtl/conv_par_to_ser_buf.sv
// Wide-to-narrow width converter: IN_W-bit words are queued in a DEPTH-entry FIFO
// and emitted as IN_W/OUT_W slices over a valid/ready output handshake.
//
// state | meaning
// IDLE  | no slice on the output; pops the FIFO head as soon as one is present
// SHIFT | valid_out=1; slice idx of the shift-register word is on data_out
module conv_par_to_ser_buf #(
  parameter int IN_W      = 32,
  parameter int OUT_W     = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             valid_in,
  input  logic [IN_W-1:0]  data_in,
  output logic             ready_in,
  output logic             valid_out,
  output logic [OUT_W-1:0] data_out,
  input  logic             ready_out,
  output logic             busy
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int IW    = $clog2(RATIO);

  generate
    if ((IN_W % OUT_W) != 0 || RATIO < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_err
      $error("conv_par_to_ser_buf: illegal IN_W/OUT_W/DEPTH combination");
    end
  endgenerate

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_nxt;
  logic [IN_W-1:0]   mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [IN_W-1:0]   shreg, shreg_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic [OUT_W-1:0]  dout, dout_nxt;
  logic              vout, vout_nxt;
  logic              push, pop, fifo_empty;
  logic [IN_W-1:0]   head, shifted;

  function automatic logic [OUT_W-1:0] first_slice(input logic [IN_W-1:0] w);
    if (MSB_FIRST) return w[IN_W-1 -: OUT_W];
    else           return w[OUT_W-1:0];
  endfunction

  // ready_in looks only at the registered count, never at ready_out
  assign ready_in   = reset_L && (count < CW'(DEPTH));
  assign push       = valid_in && ready_in;
  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];
  assign shifted    = MSB_FIRST ? (shreg << OUT_W) : (shreg >> OUT_W);

  assign valid_out  = vout;
  assign data_out   = dout;
  assign busy       = !fifo_empty || (state == SHIFT);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    dout_nxt  = dout;
    vout_nxt  = vout;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shreg_nxt = head;
          idx_nxt   = '0;
          dout_nxt  = first_slice(head);
          vout_nxt  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (vout && ready_out) begin
          if (idx == IW'(RATIO - 1)) begin
            if (!fifo_empty) begin
              pop       = 1'b1;
              shreg_nxt = head;
              idx_nxt   = '0;
              dout_nxt  = first_slice(head);
            end else begin
              vout_nxt  = 1'b0;
              dout_nxt  = '0;
              state_nxt = IDLE;
            end
          end else begin
            idx_nxt   = idx + 1'b1;
            shreg_nxt = shifted;
            dout_nxt  = first_slice(shifted);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      shreg  <= '0;
      idx    <= '0;
      dout   <= '0;
      vout   <= 1'b0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      idx   <= idx_nxt;
      dout  <= dout_nxt;
      vout  <= vout_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: doc/conv_par_to_ser_buf.md
Name: conv_par_to_ser_buf

Overview:
Parametrised wide-to-narrow width converter. It is the buffered, back-pressurable successor to the fixed 32b-to-8b converter. Input words of IN_W bits are queued in a small FIFO. Each word is then emitted as RATIO = IN_W/OUT_W consecutive OUT_W-bit slices over a valid/ready output handshake. Everything runs in a single clock domain; it sits between a wide datapath producer and a narrow link/serial stage.

Parameters:
IN_W, 32, input word width in bits
OUT_W, 8, output slice width in bits; IN_W % OUT_W == 0 and IN_W/OUT_W >= 2, otherwise elaboration must fail
DEPTH, 4, input FIFO depth in words; power of two, >= 2
MSB_FIRST, 1, 1 = slice 0 is data[IN_W-1 -: OUT_W]; 0 = slice 0 is data[OUT_W-1:0]

Ports:
clk  input  1  single clock, all logic on posedge
reset_L  input  1  synchronous, active-low reset
valid_in  input  1  input word valid
data_in  input  IN_W  input word
ready_in  output  1  FIFO can accept a word this cycle
valid_out  output  1  data_out holds a valid slice
data_out  output  OUT_W  current slice
ready_out  input  1  downstream accepts the slice this cycle
busy  output  1  FIFO non-empty or serializer active

Behaviour:
- Reset: sampled at posedge clk while reset_L=0.
  - valid_out=0, data_out=0, busy=0.
  - FIFO pointers and count=0; slice index=0; FSM=IDLE.
  - ready_in=0 while reset_L=0; ready_in=1 on the first cycle after reset_L returns to 1.
- ready_in = reset_L && (fifo_count < DEPTH). Derived from registered count only; it has no combinational path from ready_out.
- FIFO write: on the edge where valid_in && ready_in. valid_in with ready_in=0 is ignored; the producer must hold the word.
- FSM IDLE: at each edge, if the FIFO is non-empty, pop the head into the shift register, set idx=0, go to SHIFT.
  - valid_out=1 and data_out=slice 0 are registered on that same edge.
  - Latency: word accepted at edge t into an empty, idle block gives valid_out=1 after edge t+1.
- FSM SHIFT: a slice transfers on each edge with valid_out && ready_out.
  - idx<RATIO-1: idx++, data_out=next slice.
  - idx==RATIO-1 with FIFO non-empty: pop next word, idx=0, data_out=its slice 0. No bubble between words.
  - idx==RATIO-1 with FIFO empty: valid_out=0, data_out=0, go to IDLE.
- Backpressure: valid_out && !ready_out holds data_out, idx and the shift register unchanged for any number of cycles.
- Simultaneous push and pop in one edge: count unchanged, both take effect.
- Full: count==DEPTH forces ready_in=0. Total storage is DEPTH words in the FIFO plus 1 in the shift register.
- Slice ordering per MSB_FIRST. Slice k (MSB_FIRST=1) = word[IN_W-1-k*OUT_W -: OUT_W].
- busy = (fifo_count != 0) || (FSM == SHIFT).
- Reset mid-word: the partial word and all FIFO contents are discarded. Outputs follow the reset values listed above, effective at the reset edge.
- No slice is ever duplicated, dropped or reordered across words.

Test Plan:
1. Reset then idle: reset_L=0 for 2 cycles, then 1 -> valid_out=0, data_out=8'h00, busy=0; ready_in 0 during reset, 1 after.
2. Single word with MSB_FIRST=1, ready_out=1, push 32'hDDCCBBAA at edge t -> edges t+1..t+4 give DD, CC, BB, AA with valid_out=1; valid_out=0 after t+5.
3. Back-to-back with ready_out=1, push 32'hFFFFFFFF then 32'h00000003 on consecutive cycles -> 8 consecutive valid slices FF, FF, FF, FF, 00, 00, 00, 03 with no bubble; busy drops after the last.
4. Backpressure: during word 32'h11223344, drop ready_out for 3 cycles while data_out=8'h22 -> data_out stays 8'h22 with valid_out=1; then 33, 44 follow.
5. Full FIFO (DEPTH=4) with ready_out=0, offer 6 words 1..6 every cycle -> exactly 5 accepted; ready_in=0 while word 6 waits. Raising ready_out emits words 1..5 as 20 in-order slices, and word 6 is accepted once ready_in rises.
6. Reset mid-word plus LSB mode: MSB_FIRST=0, word 32'hDDCCBBAA gives AA, BB, ...; assert reset_L=0 after BB -> valid_out=0 next edge, and CC/DD are never emitted.
